spi_video_tx: RTL and testbench

- Bit-serial transmitter for the video data link: the sending end of the SPI_clk/MISO/chip_select interface used by the frame receiver.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first on MISO.
- Generates SPI_clk from CLK_40 and transmits only while the receiver holds chip_select asserted.
- Sits in the source/test-pattern FPGA, or loops back on GPIO for bring-up of the receiver.

---
 rtl/spi_video_tx.sv | 189 ++++++++++++++++++
 tb/tb_spi_video_tx.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_video_tx
// Purpose  : Bit-serial transmitter for the video data link. Takes parallel
//            words over a valid/ready handshake and shifts them out MSB-first
//            on MISO. SPI_clk is divided down from CLK_40 and is only driven
//            while the receiver holds chip_select asserted.
// Ports    : CLK_40      - system clock, every flop runs on it
//            reset       - asynchronous, active-high reset
//            tx_data     - word to send, captured on the accept edge
//            tx_valid    - source has a word
//            tx_ready    - block can accept a word this cycle
//            chip_select - from receiver, active-high, asynchronous
//            SPI_clk     - serial clock, idles low
//            MISO        - serial data, MSB first, changes while SPI_clk low
//            word_done   - one-cycle pulse after the last falling edge
//            tx_abort    - one-cycle pulse when a word in flight is dropped
//            busy        - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module spi_video_tx #(
  parameter int WORD_WIDTH  = 24,  // bits per word, >= 2
  parameter int HALF_PERIOD = 4    // CLK_40 cycles per SPI_clk half period, >= 1
) (
  input  logic                  CLK_40,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  chip_select,
  output logic                  SPI_clk,
  output logic                  MISO,
  output logic                  word_done,
  output logic                  tx_abort,
  output logic                  busy
);

  // Half-period counter needs at least one bit even when HALF_PERIOD is 1.
  localparam int c_HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int c_BIT_W  = $clog2(WORD_WIDTH);

  localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(HALF_PERIOD - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } t_state;

  t_state                r_state;
  logic                  r_cs_meta;
  logic                  r_cs_sync;
  // The bit currently on MISO lives in r_miso, so the shift register only
  // holds the bits still to come (the word minus its MSB).
  logic [WORD_WIDTH-2:0] r_shreg;
  logic [c_HALF_W-1:0]   r_half_cnt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic                  r_spi_clk;
  logic                  r_miso;
  logic                  r_word_done;
  logic                  r_tx_abort;

  logic                  w_tx_ready;
  logic                  w_accept;
  logic                  w_half_end;
  logic                  w_last_bit;

  // --------------------------------------------------------------------------
  // chip_select synchroniser. Resets to 0 so that after any reset the block
  // waits two edges before it can look ready again.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      r_cs_meta <= 1'b0;
      r_cs_sync <= 1'b0;
    end else begin
      r_cs_meta <= chip_select;
      r_cs_sync <= r_cs_meta;
    end
  end

  assign w_tx_ready = (r_state == ST_IDLE) && r_cs_sync;
  assign w_accept   = tx_valid && w_tx_ready;
  assign w_half_end = (r_half_cnt == c_HALF_LAST);
  assign w_last_bit = (r_bit_cnt == c_BIT_LAST);

  // --------------------------------------------------------------------------
  // Transmit state machine. All serial outputs come straight from flops.
  // In LOW/HIGH a deasserted cs_sync is checked first so that an abort wins
  // over the end-of-half-period transition in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_half_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_spi_clk   <= 1'b0;
      r_miso      <= 1'b0;
      r_word_done <= 1'b0;
      r_tx_abort  <= 1'b0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      r_word_done <= 1'b0;
      r_tx_abort  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_spi_clk <= 1'b0;
          r_miso    <= 1'b0;
          if (w_accept) begin
            r_shreg    <= tx_data[WORD_WIDTH-2:0];
            r_miso     <= tx_data[WORD_WIDTH-1];
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_state    <= ST_LOW;
          end
        end

        ST_LOW: begin
          if (!r_cs_sync) begin
            r_state    <= ST_IDLE;
            r_spi_clk  <= 1'b0;
            r_miso     <= 1'b0;
            r_half_cnt <= '0;
            r_tx_abort <= 1'b1;
          end else if (w_half_end) begin
            r_spi_clk  <= 1'b1;
            r_half_cnt <= '0;
            r_state    <= ST_HIGH;
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end

        ST_HIGH: begin
          if (!r_cs_sync) begin
            r_state    <= ST_IDLE;
            r_spi_clk  <= 1'b0;
            r_miso     <= 1'b0;
            r_half_cnt <= '0;
            r_tx_abort <= 1'b1;
          end else if (w_half_end) begin
            r_spi_clk  <= 1'b0;
            r_half_cnt <= '0;
            if (w_last_bit) begin
              // Falling edge of the final bit: park MISO low and report.
              r_miso      <= 1'b0;
              r_word_done <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              // MISO moves together with the falling edge, so the receiver
              // sees it stable for the whole low phase before it samples.
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_miso    <= r_shreg[WORD_WIDTH-2];
              r_shreg   <= r_shreg << 1;
              r_state   <= ST_LOW;
            end
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // word_done is high during this single cycle regardless of
          // chip_select; the word is already complete.
          r_spi_clk <= 1'b0;
          r_miso    <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = w_tx_ready;
  assign SPI_clk   = r_spi_clk;
  assign MISO      = r_miso;
  assign word_done = r_word_done;
  assign tx_abort  = r_tx_abort;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_video_tx
// Purpose  : Self-checking bench for spi_video_tx. A negedge monitor logs
//            accepts, SPI_clk rising edges (with the MISO bit seen there),
//            word_done and tx_abort pulses; scenario tasks compare the log
//            against edge numbers and bit values computed from the link rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_video_tx;

  localparam int W        = 24;
  localparam int HP       = 2;
  localparam int MW       = 2;
  localparam int MHP      = 1;
  localparam int WORD_CYC = 2 * HP * W;

  logic         CLK_40      = 1'b0;
  logic         reset       = 1'b0;
  logic         chip_select = 1'b0;
  logic         tx_valid    = 1'b0;
  logic [W-1:0] tx_data     = '0;
  logic         tx_ready, SPI_clk, MISO, word_done, tx_abort, busy;

  logic          m_cs       = 1'b0;
  logic          m_tx_valid = 1'b0;
  logic [MW-1:0] m_tx_data  = '0;
  logic          m_tx_ready, m_spi_clk, m_miso, m_word_done, m_tx_abort, m_busy;

  int tests = 0;
  int fails = 0;

  always #5 CLK_40 = ~CLK_40;

  spi_video_tx #(.WORD_WIDTH(W), .HALF_PERIOD(HP)) dut (
    .CLK_40(CLK_40), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .chip_select(chip_select), .SPI_clk(SPI_clk),
    .MISO(MISO), .word_done(word_done), .tx_abort(tx_abort), .busy(busy)
  );

  spi_video_tx #(.WORD_WIDTH(MW), .HALF_PERIOD(MHP)) dut_min (
    .CLK_40(CLK_40), .reset(reset), .tx_data(m_tx_data), .tx_valid(m_tx_valid),
    .tx_ready(m_tx_ready), .chip_select(m_cs), .SPI_clk(m_spi_clk),
    .MISO(m_miso), .word_done(m_word_done), .tx_abort(m_tx_abort), .busy(m_busy)
  );

  // Edge counter: at the negedge (or #1) after posedge number e, cyc == e.
  int cyc = 0;
  always @(posedge CLK_40) cyc <= cyc + 1;

  int           acc_q[$];
  logic [W-1:0] accd_q[$];
  int           rise_q[$];
  logic         rise_bit_q[$];
  int           done_q[$];
  int           abort_q[$];
  int           miso_bad = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_miso = 1'b0;

  always @(negedge CLK_40) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        acc_q.push_back(cyc + 1);
        accd_q.push_back(tx_data);
      end
      if (SPI_clk && !prev_sclk) begin
        rise_q.push_back(cyc);
        rise_bit_q.push_back(MISO);
      end
      if (word_done) done_q.push_back(cyc);
      if (tx_abort) abort_q.push_back(cyc);
      if ((MISO !== prev_miso) && (SPI_clk !== 1'b0)) miso_bad++;
    end
    prev_sclk = SPI_clk;
    prev_miso = MISO;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_40);
    #1;
  endtask

  task automatic clear_log;
    acc_q.delete(); accd_q.delete(); rise_q.delete(); rise_bit_q.delete();
    done_q.delete(); abort_q.delete();
  endtask

  task automatic wait_accepts(input int n, input string tag);
    int i = 0;
    while (acc_q.size() < n && i < 500) begin @(negedge CLK_40); #1; i++; end
    tests++;
    if (acc_q.size() < n) begin
      fails++;
      $display("FAIL %s_accept: got %0d accepts, required %0d", tag, acc_q.size(), n);
    end
  endtask

  task automatic wait_done(input int n, input string tag);
    int i = 0;
    while (done_q.size() < n && i < 400) begin @(negedge CLK_40); #1; i++; end
    tests++;
    if (done_q.size() < n) begin
      fails++;
      $display("FAIL %s_done_wait: got %0d word_done pulses, required %0d", tag, done_q.size(), n);
    end
  endtask

  task automatic wait_rises(input int n, input string tag);
    int i = 0;
    while (rise_q.size() < n && i < 400) begin @(negedge CLK_40); #1; i++; end
    tests++;
    if (rise_q.size() < n) begin
      fails++;
      $display("FAIL %s_rise_wait: got %0d rising edges, required %0d", tag, rise_q.size(), n);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input string tag);
    int n;
    n = acc_q.size() + 1;
    tx_data  = d;
    tx_valid = 1'b1;
    wait_accepts(n, tag);
    @(posedge CLK_40); #1;
    tx_valid = 1'b0;
  endtask

  // Reference: bit k rises at accept + 2*HP*k + HP carrying data[W-1-k];
  // word_done follows the final falling edge at accept + 2*HP*W.
  task automatic check_word(input int wi, input int rb, input int di, input string tag);
    int a, tbad, first_bad;
    logic [W-1:0] d, rx;
    tests++;
    if (wi >= acc_q.size() || rb + W > rise_q.size()) begin
      fails++;
      $display("FAIL %s_log: accepts=%0d rises=%0d, required word %0d with %0d rises from %0d",
               tag, acc_q.size(), rise_q.size(), wi, W, rb);
      return;
    end
    a = acc_q[wi]; d = accd_q[wi]; rx = '0; tbad = 0; first_bad = -1;
    for (int k = 0; k < W; k++) begin
      rx = {rx[W-2:0], rise_bit_q[rb+k]};
      if (rise_q[rb+k] != a + 2*HP*k + HP) begin
        tbad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (rx !== d) begin
      fails++;
      $display("FAIL %s_data: MISO at rising edges gave %h, required %h", tag, rx, d);
    end
    tests++;
    if (tbad != 0) begin
      fails++;
      $display("FAIL %s_timing: %0d rising edges misplaced, bit %0d at edge +%0d, required +%0d",
               tag, tbad, first_bad, rise_q[rb+first_bad] - a, 2*HP*first_bad + HP);
    end
    tests++;
    if (di >= done_q.size()) begin
      fails++;
      $display("FAIL %s_done: no word_done pulse %0d, required at edge +%0d", tag, di, WORD_CYC);
    end else if (done_q[di] != a + WORD_CYC) begin
      fails++;
      $display("FAIL %s_done: word_done at edge +%0d, required +%0d", tag, done_q[di] - a, WORD_CYC);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    tests++; if (SPI_clk !== 1'b0)   begin fails++; $display("FAIL rst_sclk: got %b required 0", SPI_clk); end
    tests++; if (MISO !== 1'b0)      begin fails++; $display("FAIL rst_miso: got %b required 0", MISO); end
    tests++; if (word_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", word_done); end
    tests++; if (tx_abort !== 1'b0)  begin fails++; $display("FAIL rst_abort: got %b required 0", tx_abort); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests++; if (tx_ready !== 1'b0)  begin fails++; $display("FAIL rst_ready: got %b required 0", tx_ready); end
    tests++; if (m_spi_clk !== 1'b0 || m_busy !== 1'b0) begin
      fails++; $display("FAIL rst_min: sclk=%b busy=%b required 0 0", m_spi_clk, m_busy);
    end
    tick(3);
    reset = 1'b0;
    m_cs  = 1'b1;
    tick(4);
    tests++; if (tx_ready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_cs_low_idle: ready=%b busy=%b required 0 0", tx_ready, busy);
    end
  endtask

  task automatic test_basic;
    int a;
    clear_log();
    chip_select = 1'b1;
    tick(3);
    send_word(24'hA5C30F, "basic");
    wait_done(1, "basic");
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_in_done: got %b required 0", tx_ready); end
    @(posedge CLK_40); #1;
    tests++; if (tx_ready !== 1'b1 || word_done !== 1'b0) begin
      fails++; $display("FAIL basic_ready_after: ready=%b done=%b required 1 0", tx_ready, word_done);
    end
    tick(3);
    tests++; if (rise_q.size() != W || done_q.size() != 1) begin
      fails++; $display("FAIL basic_counts: rises=%0d dones=%0d required %0d 1", rise_q.size(), done_q.size(), W);
    end
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    check_word(0, 0, 0, "basic");
    tests++; if (accd_q.size() < 1 || accd_q[0] !== 24'hA5C30F) begin
      fails++; $display("FAIL basic_capture: accept log empty or wrong word at edge %0d", a);
    end
  endtask

  task automatic test_random_words;
    logic [W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      d = W'($urandom);
      send_word(d, "rand");
      wait_done(1, "rand");
      tick(2);
      check_word(0, 0, 0, "rand");
    end
  endtask

  task automatic test_back_to_back;
    clear_log();
    tx_data  = 24'hFFFFFF;
    tx_valid = 1'b1;
    wait_accepts(1, "b2b");
    @(posedge CLK_40); #1;
    tx_data = 24'h000001;
    wait_accepts(2, "b2b");
    @(posedge CLK_40); #1;
    tx_valid = 1'b0;
    wait_done(2, "b2b");
    tick(3);
    tests++;
    if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != WORD_CYC + 2) begin
      fails++; $display("FAIL b2b_period: word period %0d, required %0d",
                        (acc_q.size() < 2) ? -1 : acc_q[1] - acc_q[0], WORD_CYC + 2);
    end
    tests++; if (rise_q.size() != 2*W || done_q.size() != 2) begin
      fails++; $display("FAIL b2b_counts: rises=%0d dones=%0d required %0d 2", rise_q.size(), done_q.size(), 2*W);
    end
    check_word(0, 0, 0, "b2b_w0");
    check_word(1, W, 1, "b2b_w1");
  endtask

  task automatic test_backpressure;
    int bad_rdy = 0, bad_clk = 0, p;
    clear_log();
    chip_select = 1'b0;
    tick(3);
    tx_data  = W'($urandom);
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_40);
      if (tx_ready !== 1'b0) bad_rdy++;
      if (SPI_clk !== 1'b0) bad_clk++;
    end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL bp_ready: high in %0d of 10 cycles, required 0", bad_rdy); end
    tests++; if (bad_clk != 0 || acc_q.size() != 0) begin
      fails++; $display("FAIL bp_sclk: sclk high %0d cycles accepts=%0d, required 0 0", bad_clk, acc_q.size());
    end
    @(posedge CLK_40); #1;
    p = cyc;
    chip_select = 1'b1;
    @(posedge CLK_40); #1;
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_1st: got %b required 0", tx_ready); end
    @(posedge CLK_40); #1;
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_2nd: got %b required 1", tx_ready); end
    @(posedge CLK_40); #1;
    tx_valid = 1'b0;
    wait_done(1, "bp");
    tick(2);
    tests++; if (acc_q.size() != 1 || acc_q[0] != p + 3) begin
      fails++; $display("FAIL bp_accept_edge: accepts=%0d first=%0d required 1 at %0d",
                        acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : -1, p + 3);
    end
    check_word(0, 0, 0, "bp");
  endtask

  task automatic test_abort;
    logic [W-1:0] d;
    int r10;
    clear_log();
    chip_select = 1'b1;
    tick(3);
    d = W'($urandom);
    d[W-11] = 1'b1;  // bit on MISO when chip_select drops
    send_word(d, "abort");
    wait_rises(10, "abort");
    chip_select = 1'b0;
    r10 = (rise_q.size() >= 10) ? rise_q[9] : 0;
    repeat (3) @(posedge CLK_40);
    #1;
    tests++; if (SPI_clk !== 1'b0 || MISO !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_outputs: sclk=%b miso=%b busy=%b required 0 0 0", SPI_clk, MISO, busy);
    end
    tests++; if (tx_abort !== 1'b1) begin fails++; $display("FAIL abort_pulse: got %b required 1", tx_abort); end
    tick(20);
    tests++; if (abort_q.size() != 1 || done_q.size() != 0) begin
      fails++; $display("FAIL abort_counts: aborts=%0d dones=%0d required 1 0", abort_q.size(), done_q.size());
    end
    tests++; if (rise_q.size() != 10 || (abort_q.size() > 0 && abort_q[0] > r10 + 3)) begin
      fails++; $display("FAIL abort_stop: rises=%0d abort at +%0d, required 10 and <= +3",
                        rise_q.size(), (abort_q.size() > 0) ? abort_q[0] - r10 : -1);
    end
    chip_select = 1'b1;
    tick(3);
    clear_log();
    send_word(W'($urandom), "abort_next");
    wait_done(1, "abort_next");
    tick(2);
    check_word(0, 0, 0, "abort_next");
  endtask

  task automatic test_reset_mid_word;
    logic [W-1:0] d;
    clear_log();
    d = W'($urandom);
    d[W-6] = 1'b1;  // bit 5 is a one so MISO visibly drops
    send_word(d, "rstmid");
    wait_rises(6, "rstmid");
    tests++; if (SPI_clk !== 1'b1 || MISO !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: sclk=%b miso=%b busy=%b required 1 1 1", SPI_clk, MISO, busy);
    end
    reset = 1'b1;
    #1;
    tests++; if (SPI_clk !== 1'b0 || MISO !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: sclk=%b miso=%b busy=%b required 0 0 0", SPI_clk, MISO, busy);
    end
    @(posedge CLK_40); #1;
    reset = 1'b0;
    @(posedge CLK_40); #1;
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready_1st: got %b required 0", tx_ready); end
    @(posedge CLK_40); #1;
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_2nd: got %b required 1", tx_ready); end
    tick(5);
    tests++; if (done_q.size() != 0 || abort_q.size() != 0 || SPI_clk !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet: dones=%0d aborts=%0d sclk=%b required 0 0 0",
                        done_q.size(), abort_q.size(), SPI_clk);
    end
  endtask

  task automatic test_min_divide;
    logic [MW-1:0] dv [2];
    logic [6:0]    got_clk, exp_clk, got_wd, exp_wd, got_miso;
    logic [MW-1:0] got_bits;
    dv[0] = 2'b10;
    dv[1] = MW'($urandom);
    for (int j = 0; j < 2; j++) begin
      tick(1);
      tests++; if (m_tx_ready !== 1'b1) begin fails++; $display("FAIL min_ready: got %b required 1", m_tx_ready); end
      m_tx_data  = dv[j];
      m_tx_valid = 1'b1;
      @(posedge CLK_40); #1;
      m_tx_valid = 1'b0;
      for (int e = 0; e < 7; e++) begin
        @(negedge CLK_40);
        got_clk[e]  = m_spi_clk;
        got_wd[e]   = m_word_done;
        got_miso[e] = m_miso;
      end
      for (int e = 0; e < 7; e++) begin
        exp_clk[e] = (e < 2*MHP*MW) ? (((e / MHP) % 2) == 1) : 1'b0;
        exp_wd[e]  = (e == 2*MHP*MW);
      end
      for (int k = 0; k < MW; k++) got_bits[MW-1-k] = got_miso[MHP + 2*MHP*k];
      tests++; if (got_clk !== exp_clk) begin
        fails++; $display("FAIL min_sclk: sequence %b, required %b (bit e = after edge e)", got_clk, exp_clk);
      end
      tests++; if (got_bits !== dv[j]) begin
        fails++; $display("FAIL min_miso: bits %b at rising edges, required %b", got_bits, dv[j]);
      end
      tests++; if (got_wd !== exp_wd || m_tx_abort !== 1'b0) begin
        fails++; $display("FAIL min_done: word_done %b abort=%b, required %b 0", got_wd, m_tx_abort, exp_wd);
      end
    end
  endtask

  task automatic test_miso_timing;
    tests++;
    if (miso_bad != 0) begin
      fails++; $display("FAIL miso_while_sclk_high: %0d changes, required 0", miso_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_words();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_word();
    test_min_divide();
    test_miso_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
